// File: rtl/ms_timer_pkg.sv
// Shared IO package for the millisecond timer/counter blocks: default tick rate,
// data width and the countdown timer state encoding.
package ms_timer_pkg;

    localparam int unsigned MS_TIMER_CLKS_PER_MS = 50000;
    localparam int unsigned MS_TIMER_DATA_W      = 32;

    typedef enum logic {
        MST_IDLE = 1'b0,
        MST_RUN  = 1'b1
    } ms_timer_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts enabled cycles and flags the last cycle of each
// CLKS_PER_MS window. Shared with the free-running millisecond counter.
module ms_tick_gen #(
    parameter int unsigned CLKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_c_o
);

    localparam int unsigned PRESC_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLKS_PER_MS - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    // Wrapping at the tick means a reload needs no extra cycle between periods.
    always_comb begin
        presc_d = presc_q;
        if (clear_i) begin
            presc_d = '0;
        end else if (enable_i) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_c_o = enable_i && (presc_q == PRESC_MAX);

endmodule

// File: rtl/ms_timer.sv
// Programmable millisecond countdown timer with one-cycle expiry interrupt.
// Define MS_TIMER_PERIODIC_EN to enable auto-reload (periodic) mode.
module ms_timer
    import ms_timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS = MS_TIMER_CLKS_PER_MS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [MS_TIMER_DATA_W-1:0] reload_val_i,
    input  logic                       reload_we_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       periodic_i,
    output logic [MS_TIMER_DATA_W-1:0] count_o,
    output logic                       busy_o,
    output logic                       irq_o
);

    localparam int unsigned W = MS_TIMER_DATA_W;

    ms_timer_state_t state_q;
    ms_timer_state_t state_d;
    logic [W-1:0]    reload_q;
    logic [W-1:0]    reload_d;
    logic [W-1:0]    count_q;
    logic [W-1:0]    count_d;
    logic            irq_q;
    logic            irq_d;
    logic            tick_c;
    logic            run_c;
    logic            presc_clear_c;
    logic            mode_c;

`ifdef MS_TIMER_PERIODIC_EN
    logic mode_q;
    logic mode_d;
    assign mode_c = mode_q;
`else
    logic unused_periodic;
    assign unused_periodic = periodic_i;
    assign mode_c          = 1'b0;
`endif

    // A same-cycle write is visible to a start in that cycle.
    assign reload_d      = reload_we_i ? reload_val_i : reload_q;
    assign run_c         = (state_q == MST_RUN);
    assign presc_clear_c = start_i | stop_i;

    ms_tick_gen #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (presc_clear_c),
        .enable_i (run_c),
        .tick_c_o (tick_c)
    );

    // Priority in RUN: stop > restart > expiry tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        irq_d   = 1'b0;
`ifdef MS_TIMER_PERIODIC_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            MST_IDLE: begin
                if (start_i && !stop_i && (reload_d != '0)) begin
                    state_d = MST_RUN;
                    count_d = reload_d;
`ifdef MS_TIMER_PERIODIC_EN
                    mode_d  = periodic_i;
`endif
                end
            end
            MST_RUN: begin
                if (stop_i) begin
                    state_d = MST_IDLE;
                    count_d = '0;
                end else if (start_i) begin
                    if (reload_d == '0) begin
                        state_d = MST_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = reload_d;
`ifdef MS_TIMER_PERIODIC_EN
                        mode_d  = periodic_i;
`endif
                    end
                end else if (tick_c) begin
                    if (count_q > W'(1)) begin
                        count_d = count_q - W'(1);
                    end else begin
                        count_d = '0;
                        irq_d   = (count_q == W'(1));
                        if (mode_c && (count_q == W'(1)) && (reload_q != '0)) begin
                            count_d = reload_q;
                        end else begin
                            state_d = MST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = MST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MST_IDLE;
            reload_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
`ifdef MS_TIMER_PERIODIC_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
`ifdef MS_TIMER_PERIODIC_EN
            mode_q   <= mode_d;
`endif
        end
    end

    assign count_o = count_q;
    assign busy_o  = run_c;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_ms_timer.sv
// Scoreboard bench for ms_timer at CLKS_PER_MS=4: expected irq cycles are queued
// at stimulus time and matched by an independent irq monitor.
module tb_ms_timer;

    localparam int unsigned C = 4;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic [31:0] reload_val = '0;
    logic        reload_we  = 1'b0;
    logic        start      = 1'b0;
    logic        stop       = 1'b0;
    logic        periodic   = 1'b0;
    logic [31:0] count;
    logic        busy;
    logic        irq;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned exp_q[$];
    int unsigned mon_exp;
    bit          mon_en   = 1'b0;

    ms_timer #(
        .CLKS_PER_MS (C)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reload_val_i (reload_val),
        .reload_we_i  (reload_we),
        .start_i      (start),
        .stop_i       (stop),
        .periodic_i   (periodic),
        .count_o      (count),
        .busy_o       (busy),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    // Edge index: after edge k and before edge k+1, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int unsigned t);
        while (cyc < t) tick1();
    endtask

    task automatic write_reload(input logic [31:0] v);
        reload_val = v;
        reload_we  = 1'b1;
        tick1();
        reload_we  = 1'b0;
    endtask

    // Returns n, the edge that samples the start pulse.
    task automatic pulse_start(output int unsigned n);
        start = 1'b1;
        n     = cyc + 1;
        tick1();
        start = 1'b0;
    endtask

    // irq monitor: every pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        if (mon_en && irq) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL irq_unexpected: irq high at cycle %0d, required none", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("irq_cycle", cyc, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick1();

        // One-shot, reload=3
        write_reload(32'd3);
        periodic = 1'b0;
        pulse_start(n);
        exp_q.push_back(n + 3 * C);
        chk("os_busy_start", 32'(busy), 32'd1);
        chk("os_count_start", count, 32'd3);
        go_to(n + 3);
        chk("os_count_n3", count, 32'd3);
        go_to(n + 4);
        chk("os_count_n4", count, 32'd2);
        go_to(n + 8);
        chk("os_count_n8", count, 32'd1);
        go_to(n + 12);
        chk("os_count_n12", count, 32'd0);
        chk("os_busy_n12", 32'(busy), 32'd0);
        go_to(n + 16);

        // Periodic, reload=2
        write_reload(32'd2);
        periodic = 1'b1;
        pulse_start(n);
        periodic = 1'b0;
`ifdef MS_TIMER_PERIODIC_EN
        for (int k = 1; k <= 5; k++) exp_q.push_back(n + 8 * k);
        go_to(n + 41);
        chk("per_busy_run", 32'(busy), 32'd1);
        chk("per_count_reloaded", count, 32'd2);
        stop = 1'b1;
        tick1();
        stop = 1'b0;
        chk("per_stop_count", count, 32'd0);
        chk("per_stop_busy", 32'(busy), 32'd0);
        go_to(n + 70);
`else
        exp_q.push_back(n + 8);
        go_to(n + 9);
        chk("oneshot_only_busy", 32'(busy), 32'd0);
        chk("oneshot_only_count", count, 32'd0);
        go_to(n + 30);
`endif

        // Start with reload=0 is ignored
        write_reload(32'd0);
        pulse_start(n);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_count", count, 32'd0);
        go_to(n + 10);

        // Same-cycle reload write and start
        reload_val = 32'd5;
        reload_we  = 1'b1;
        pulse_start(n);
        reload_we  = 1'b0;
        exp_q.push_back(n + 20);
        chk("same_busy", 32'(busy), 32'd1);
        chk("same_count", count, 32'd5);
        go_to(n + 19);
        chk("same_count_n19", count, 32'd1);
        go_to(n + 20);
        chk("same_busy_end", 32'(busy), 32'd0);
        go_to(n + 24);

        // Restart coinciding with the expiry tick
        write_reload(32'd2);
        pulse_start(n);
        go_to(n + 7);
        chk("rs_count_pre", count, 32'd1);
        start = 1'b1;
        tick1();
        start = 1'b0;
        chk("rs_count", count, 32'd2);
        chk("rs_busy", 32'(busy), 32'd1);
        exp_q.push_back(n + 16);
        go_to(n + 16);
        chk("rs_busy_end", 32'(busy), 32'd0);
        go_to(n + 20);

        // Stop coinciding with the expiry tick
        write_reload(32'd1);
        pulse_start(n);
        go_to(n + 3);
        stop = 1'b1;
        tick1();
        stop = 1'b0;
        chk("se_busy", 32'(busy), 32'd0);
        chk("se_count", count, 32'd0);
        go_to(n + 12);

        // Stop and start together in RUN
        write_reload(32'd2);
        pulse_start(n);
        go_to(n + 2);
        start = 1'b1;
        stop  = 1'b1;
        tick1();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", 32'(busy), 32'd0);
        chk("ss_count", count, 32'd0);
        go_to(n + 20);

        // Asynchronous reset mid-run
        write_reload(32'd3);
        pulse_start(n);
        go_to(n + 5);
        chk("ar_count_pre", count, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("ar_count", count, 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_irq", 32'(irq), 32'd0);
        tick1();
        rst_n = 1'b1;
        tick1();
        go_to(n + 30);
        chk("ar_busy_after", 32'(busy), 32'd0);
        pulse_start(n);
        chk("ar_start_reload_cleared", 32'(busy), 32'd0);
        go_to(n + 16);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ms_timer.md
# ms_timer

Programmable millisecond countdown timer; the event-generating counterpart to the free-running millisecond counter. Software loads a reload value in milliseconds and starts the timer. The block divides the system clock down to 1 ms ticks, counts down, and raises a one-cycle interrupt pulse on expiry. It sits in the IO block next to the millisecond counter and drives one line of the interrupt controller.

## Interface
- CLKS_PER_MS, 50000, system clock cycles per millisecond tick (50 MHz clock); minimum 2
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (low = reset)
- reload_val  in  32  reload value in ms, captured when reload_we is high
- reload_we  in  1  write strobe for reload_val
- start  in  1  one-cycle start/restart pulse
- stop  in  1  one-cycle stop pulse
- periodic  in  1  mode select sampled at start: 1 = auto-reload, 0 = one-shot
- count  out  32  remaining ms in the current period
- busy  out  1  high while in RUN
- irq  out  1  one-cycle expiry pulse

## Operation
- Registers: reload (32 b), count (32 b), prescaler (width clog2(CLKS_PER_MS)), mode bit, state.
- Reset values: reload=0, count=0, prescaler=0, mode=0, state=IDLE, busy=0, irq=0.
- reload_we: reload <= reload_val in any state. In RUN it affects only the next auto-reload, never the current count.
- States:
  - IDLE
    - start with reload != 0 (or with reload_we high and reload_val != 0 in the same cycle, new value used): count <= reload, prescaler <= 0, mode <= periodic, go to RUN.
    - start with the effective reload == 0: ignored; stays IDLE, no irq.
  - RUN
    - prescaler increments each cycle. At CLKS_PER_MS-1 it wraps to 0 and produces a tick.
    - On a tick with count > 1: count <= count-1.
    - On a tick with count == 1: count <= 0, irq <= 1 for exactly one cycle.
      - mode=0: go to IDLE.
      - mode=1: count <= reload and stay in RUN. If reload == 0 at this point, go to IDLE instead.
- start in RUN restarts: count <= reload, prescaler <= 0, mode <= periodic. No irq, even if this coincides with an expiry tick.
- stop in RUN: go to IDLE, count and prescaler cleared, no irq. stop in IDLE has no effect.
- Simultaneous events:
  - stop and start together: stop wins.
  - stop coinciding with an expiry tick: stop wins, no irq.
- irq is registered and never asserted in IDLE except on the cycle immediately after the expiring tick.

## Timing
- Start sampled at edge N. The first decrement occurs at edge N+CLKS_PER_MS.
- irq is high in the cycle following edge N+reload*CLKS_PER_MS.
- Periodic mode: irq pulses are exactly reload*CLKS_PER_MS cycles apart with no drift. The reload edge does not consume a prescaler cycle.
- count and busy are registered; they reflect a start or stop from the following cycle.
- Reset asserted mid-run: all registers return to reset values immediately (asynchronous). Operation resumes only after a new start.

## Configuration
- MS_TIMER_PERIODIC_EN defined: the periodic input and auto-reload behave as above.
- MS_TIMER_PERIODIC_EN undefined:
  - The periodic input is ignored, the mode bit is tied 0 and no mode register exists.
  - Every expiry returns to IDLE (one-shot only).
  - All other behaviour is unchanged.

## Structure
- Shared IO package holds:
  - default CLKS_PER_MS constant (50000)
  - state enum ms_timer_state_t {MST_IDLE, MST_RUN}
- Sub-module ms_tick_gen: the prescaler, with inputs clear and enable, output tick, parameter CLKS_PER_MS. It is reusable by the millisecond counter.
- The top level holds the reload/count registers and the FSM.

## Test plan
- Sim with CLKS_PER_MS=4: write reload=3, pulse start at edge N -> busy=1 at N+1; count 3→2→1→0 at N+4, N+8, N+12; irq high one cycle after N+12; busy=0.
- Periodic mode, reload=2, CLKS_PER_MS=4 -> irq pulses every 8 cycles for 5 periods; after stop, count=0, busy=0, no further irq.
- Start with reload=0 -> no state change, busy stays 0, no irq. Same-cycle reload_we(5)+start -> first irq 20 cycles later.
- Restart mid-run at count=1 coinciding with the expiry tick -> no irq; count=reload; next irq reload*4 cycles later.
- stop and start asserted together in RUN -> IDLE, no irq. Assert reset (low) mid-run -> outputs zero immediately, no irq after release.
- Build without MS_TIMER_PERIODIC_EN, periodic=1, reload=2 -> exactly one irq, then IDLE.
